// File: rtl/dead_time_bridge_pkg.sv
// Shared types and constants for the dead-time bridge and its leg controllers.
package dead_time_bridge_pkg;

  // Per-leg controller state, also exported on the debug bus.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HI_ON = 2'd1,
    ST_LO_ON = 2'd2,
    ST_DEAD  = 2'd3
  } leg_state_t;

  // What the command word asks of one leg.
  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_HI      = 2'd1,
    REQ_LO      = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_t;

  // Leg indices into the command / gate / busy vectors.
  localparam int LEG_A = 0;
  localparam int LEG_B = 1;

  // Decode one (high, low) command pair into a leg request.
  function automatic req_t decode_req(input logic hi, input logic lo);
    req_t r;
    case ({hi, lo})
      2'b10:   r = REQ_HI;
      2'b01:   r = REQ_LO;
      2'b11:   r = REQ_ILLEGAL;
      default: r = REQ_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dead_time_bridge_if.sv
// Bus between the command generator / supervisor and the dead-time bridge.
// All signals are level-sampled every clock; there is no valid/ready
// handshake, a command is simply the current value of i_MOS_cmd.
interface dead_time_bridge_if #(
  parameter int DT_WIDTH = 8
);
  logic [3:0]          i_MOS_cmd;
  logic [DT_WIDTH-1:0] i_deadtime;
  logic                i_enable;
  logic                i_fault_clr;
  logic [3:0]          o_MOSFET;
  logic                o_fault;
  logic [1:0]          o_busy;
  logic [3:0]          o_dbg_state;   // {leg B state, leg A state}

  // Side that issues commands and observes the gates.
  modport master (
    output i_MOS_cmd, i_deadtime, i_enable, i_fault_clr,
    input  o_MOSFET, o_fault, o_busy, o_dbg_state
  );

  // The bridge itself.
  modport slave (
    input  i_MOS_cmd, i_deadtime, i_enable, i_fault_clr,
    output o_MOSFET, o_fault, o_busy, o_dbg_state
  );
endinterface

// File: rtl/dead_time_bridge_dt_leg.sv
// One bridge leg: state machine, dead-time down-counter and gate registers.
// Gates only change together with the state, so high and low are never on
// in the same cycle and every turn-on is preceded by a full dead interval.
module dt_leg
  import dead_time_bridge_pkg::*;
#(
  parameter int DT_WIDTH = 8,
  parameter int DT_MIN   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_hi_i,
  input  logic                req_lo_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  input  logic                enable_i,
  input  logic                force_off_i,
  output logic                gate_hi_o,
  output logic                gate_lo_o,
  output logic                busy_o,
  output leg_state_t          state_o
);

  leg_state_t          state_q;
  logic [DT_WIDTH-1:0] cnt_q;
  logic                gate_hi_q;
  logic                gate_lo_q;
  logic                busy_q;

  req_t                req;
  logic [DT_WIDTH-1:0] dt_load;

  assign req = decode_req(req_hi_i, req_lo_i);

  // Programmed dead time, raised to the enforced minimum.
  assign dt_load = (deadtime_i < DT_WIDTH'(DT_MIN)) ? DT_WIDTH'(DT_MIN) : deadtime_i;

  // Leg FSM: disable and fault win over everything, otherwise walk the
  // OFF -> DEAD -> ON -> DEAD cycle. The counter holds the number of dead
  // cycles still to spend including the current one, so leaving DEAD when
  // it reads 1 gives exactly dt_load cycles with both gates low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!enable_i || force_off_i) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (req == REQ_HI || req == REQ_LO) begin
            state_q <= ST_DEAD;
            cnt_q   <= dt_load;
            busy_q  <= 1'b1;
          end
        end
        ST_HI_ON: begin
          if (req != REQ_HI) begin
            state_q   <= ST_DEAD;
            cnt_q     <= dt_load;
            gate_hi_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_LO_ON: begin
          if (req != REQ_LO) begin
            state_q   <= ST_DEAD;
            cnt_q     <= dt_load;
            gate_lo_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (cnt_q <= DT_WIDTH'(1)) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            case (req)
              REQ_HI: begin
                state_q   <= ST_HI_ON;
                gate_hi_q <= 1'b1;
              end
              REQ_LO: begin
                state_q   <= ST_LO_ON;
                gate_lo_q <= 1'b1;
              end
              default: state_q <= ST_OFF;
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= ST_OFF;
          cnt_q     <= '0;
          gate_hi_q <= 1'b0;
          gate_lo_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign gate_hi_o = gate_hi_q;
  assign gate_lo_o = gate_lo_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;

endmodule

// File: rtl/dead_time_bridge.sv
// Dead-time bridge: registers the raw MOSFET command word and enable, keeps
// the sticky illegal-command fault, and maps the word onto two leg
// controllers (A = bits 0/2, B = bits 1/3; low nibble half is high side).
module dead_time_bridge
  import dead_time_bridge_pkg::*;
#(
  parameter int DT_WIDTH = 8,
  parameter int DT_MIN   = 1
) (
  input  logic          i_CLK,
  input  logic          i_RSTn,
  dead_time_bridge_if.slave bus
);

  logic [3:0] cmd_q;
  logic       en_q;
  logic       fault_q;
  logic       fault_d;
  logic       illegal;

  logic [1:0] gate_hi;
  logic [1:0] gate_lo;
  logic [1:0] busy;
  leg_state_t state_a;
  leg_state_t state_b;

  // Either leg asking for both switches at once.
  assign illegal = (cmd_q[LEG_A] & cmd_q[LEG_A+2]) | (cmd_q[LEG_B] & cmd_q[LEG_B+2]);

  // Sticky fault: a new illegal command beats a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (bus.i_fault_clr) fault_d = 1'b0;
    if (illegal)         fault_d = 1'b1;
  end

  // Input stage and fault flag.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      cmd_q   <= 4'b0000;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cmd_q   <= bus.i_MOS_cmd;
      en_q    <= bus.i_enable;
      fault_q <= fault_d;
    end
  end

  dt_leg #(
    .DT_WIDTH (DT_WIDTH),
    .DT_MIN   (DT_MIN)
  ) u_leg_a (
    .clk_i       (i_CLK),
    .rst_ni      (i_RSTn),
    .req_hi_i    (cmd_q[LEG_A]),
    .req_lo_i    (cmd_q[LEG_A+2]),
    .deadtime_i  (bus.i_deadtime),
    .enable_i    (en_q),
    .force_off_i (fault_q),
    .gate_hi_o   (gate_hi[LEG_A]),
    .gate_lo_o   (gate_lo[LEG_A]),
    .busy_o      (busy[LEG_A]),
    .state_o     (state_a)
  );

  dt_leg #(
    .DT_WIDTH (DT_WIDTH),
    .DT_MIN   (DT_MIN)
  ) u_leg_b (
    .clk_i       (i_CLK),
    .rst_ni      (i_RSTn),
    .req_hi_i    (cmd_q[LEG_B]),
    .req_lo_i    (cmd_q[LEG_B+2]),
    .deadtime_i  (bus.i_deadtime),
    .enable_i    (en_q),
    .force_off_i (fault_q),
    .gate_hi_o   (gate_hi[LEG_B]),
    .gate_lo_o   (gate_lo[LEG_B]),
    .busy_o      (busy[LEG_B]),
    .state_o     (state_b)
  );

  assign bus.o_MOSFET    = {gate_lo, gate_hi};
  assign bus.o_fault     = fault_q;
  assign bus.o_busy      = busy;
  assign bus.o_dbg_state = {state_b, state_a};

endmodule

// File: tb/tb_dead_time_bridge.sv
// Directed bench for dead_time_bridge. Inputs change 1 time unit after the
// rising edge; outputs are checked right after that, i.e. they reflect the
// edge just taken. A negedge monitor checks the shoot-through invariant.
module tb_dead_time_bridge;
  import dead_time_bridge_pkg::*;

  localparam int DT_WIDTH = 8;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];

  dead_time_bridge_if #(.DT_WIDTH(DT_WIDTH)) bus ();

  dead_time_bridge #(
    .DT_WIDTH (DT_WIDTH),
    .DT_MIN   (1)
  ) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shoot-through monitor.
  always @(negedge clk) begin
    check("inv_leg_a", {31'd0, bus.o_MOSFET[0] & bus.o_MOSFET[2]}, 32'd0);
    check("inv_leg_b", {31'd0, bus.o_MOSFET[1] & bus.o_MOSFET[3]}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [7:0] dt);
    bus.i_MOS_cmd  = cmd;
    bus.i_deadtime = dt;
  endtask

  // Queue n expected gate words.
  task automatic push_exp(input int n, input logic [3:0] mos);
    for (int i = 0; i < n; i++) exp_q.push_back(mos);
  endtask

  // Take one edge per queued word and compare gates.
  task automatic drain(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check(tag, {28'd0, bus.o_MOSFET}, {28'd0, e});
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] mos, input logic [1:0] busy,
                         input logic fault);
    check({tag, "_mos"},   {28'd0, bus.o_MOSFET}, {28'd0, mos});
    check({tag, "_busy"},  {30'd0, bus.o_busy},   {30'd0, busy});
    check({tag, "_fault"}, {31'd0, bus.o_fault},  {31'd0, fault});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    bus.i_MOS_cmd   = 4'b0000;
    bus.i_deadtime  = 8'd5;
    bus.i_enable    = 1'b0;
    bus.i_fault_clr = 1'b0;
    repeat (2) tick();
    chk_out("reset", 4'b0000, 2'b00, 1'b0);
    check("reset_state", {28'd0, bus.o_dbg_state}, {28'd0, ST_OFF, ST_OFF});
    rst_n = 1'b1;
    tick();

    // First turn-on: 5-cycle dead interval on both legs.
    bus.i_enable = 1'b1;
    drive(4'b1001, 8'd5);
    tick();
    chk_out("t1_reg", 4'b0000, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t1_dead", 4'b0000, 2'b11, 1'b0);
    end
    tick();
    chk_out("t1_on", 4'b1001, 2'b00, 1'b0);
    check("t1_state", {28'd0, bus.o_dbg_state}, {28'd0, ST_LO_ON, ST_HI_ON});

    // Commutation 1001 -> 0110 with 3-cycle dead time.
    drive(4'b0110, 8'd3);
    push_exp(1, 4'b1001);
    push_exp(3, 4'b0000);
    push_exp(1, 4'b0110);
    drain("t2_swap");

    // dt=0 is raised to 1 cycle; only leg A toggles.
    drive(4'b0011, 8'd0);
    tick();
    check("t3_reg", {28'd0, bus.o_MOSFET}, 32'h6);
    tick();
    chk_out("t3_min", 4'b0010, 2'b01, 1'b0);
    tick();
    chk_out("t3_on", 4'b0011, 2'b00, 1'b0);

    // dt changed 2 -> 7 mid-interval: this interval 2, next 7.
    drive(4'b0110, 8'd2);
    tick();
    check("t3b_reg", {28'd0, bus.o_MOSFET}, 32'h3);
    tick();
    check("t3b_d1", {28'd0, bus.o_MOSFET}, 32'h2);
    bus.i_deadtime = 8'd7;
    push_exp(1, 4'b0010);
    push_exp(1, 4'b0110);
    drain("t3b_cur");
    bus.i_MOS_cmd = 4'b0011;
    push_exp(1, 4'b0110);
    push_exp(7, 4'b0010);
    push_exp(1, 4'b0011);
    drain("t3b_next");

    // Request toggles during a 6-cycle dead interval; interval not shortened.
    drive(4'b0110, 8'd6);
    tick();
    check("t4_reg", {28'd0, bus.o_MOSFET}, 32'h3);
    tick();
    check("t4_d1", {28'd0, bus.o_MOSFET}, 32'h2);
    bus.i_MOS_cmd = 4'b0011;
    tick();
    check("t4_d2", {28'd0, bus.o_MOSFET}, 32'h2);
    bus.i_MOS_cmd = 4'b0110;
    tick();
    check("t4_d3", {28'd0, bus.o_MOSFET}, 32'h2);
    bus.i_MOS_cmd = 4'b0011;
    push_exp(3, 4'b0010);
    push_exp(1, 4'b0011);
    drain("t4_tail");

    // Illegal pattern on leg A for one cycle sets the sticky fault.
    drive(4'b0101, 8'd4);
    tick();
    chk_out("t5_reg", 4'b0011, 2'b00, 1'b0);
    bus.i_MOS_cmd = 4'b0011;
    tick();
    check("t5_set_fault", {31'd0, bus.o_fault}, 32'd1);
    check("t5_set_mos", {28'd0, bus.o_MOSFET}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t5_hold", 4'b0000, 2'b00, 1'b1);
    end
    bus.i_fault_clr = 1'b1;
    tick();
    bus.i_fault_clr = 1'b0;
    chk_out("t5_clr", 4'b0000, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t5_dead", 4'b0000, 2'b11, 1'b0);
    end
    tick();
    chk_out("t5_on", 4'b0011, 2'b00, 1'b0);

    // Set beats clear when both happen together.
    bus.i_MOS_cmd = 4'b1111;
    repeat (2) tick();
    chk_out("t5b_set", 4'b0000, 2'b11, 1'b1);
    bus.i_fault_clr = 1'b1;
    tick();
    check("t5b_prio", {31'd0, bus.o_fault}, 32'd1);
    bus.i_fault_clr = 1'b0;
    bus.i_MOS_cmd   = 4'b0000;
    tick();
    bus.i_fault_clr = 1'b1;
    tick();
    bus.i_fault_clr = 1'b0;
    chk_out("t5b_clr", 4'b0000, 2'b00, 1'b0);

    // Disable mid-dead-interval.
    drive(4'b0011, 8'd2);
    push_exp(3, 4'b0000);
    push_exp(1, 4'b0011);
    drain("t6_up");
    drive(4'b0110, 8'd10);
    tick();
    tick();
    chk_out("t6_dead", 4'b0010, 2'b01, 1'b0);
    bus.i_enable = 1'b0;
    tick();
    chk_out("t6_en_reg", 4'b0010, 2'b01, 1'b0);
    tick();
    chk_out("t6_off", 4'b0000, 2'b00, 1'b0);
    check("t6_state", {28'd0, bus.o_dbg_state}, {28'd0, ST_OFF, ST_OFF});

    // Re-enable, then asynchronous reset while HI_ON.
    bus.i_enable = 1'b1;
    drive(4'b0011, 8'd2);
    tick();
    chk_out("t6_re_reg", 4'b0000, 2'b00, 1'b0);
    tick();
    chk_out("t6_re_dead", 4'b0000, 2'b11, 1'b0);
    push_exp(1, 4'b0000);
    push_exp(1, 4'b0011);
    drain("t6_re_on");
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6_async", 4'b0000, 2'b00, 1'b0);
    check("t6_async_state", {28'd0, bus.o_dbg_state}, {28'd0, ST_OFF, ST_OFF});
    bus.i_enable  = 1'b0;
    bus.i_MOS_cmd = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_out("t6_rel", 4'b0000, 2'b00, 1'b0);
    check("t6_rel_state", {28'd0, bus.o_dbg_state}, {28'd0, ST_OFF, ST_OFF});

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
